// File: rtl/param_conv_systolic_engine.sv
// Parametrised 2-D valid-convolution engine: serial image/filter load, skewed
// output-stationary OUT x OUT MAC array, raster-order valid/ready result stream.
module param_conv_systolic_engine #(
    parameter int DW    = 8,
    parameter int IMG   = 4,
    parameter int KER   = 3,
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    localparam int OUT  = IMG - KER + 1,
    localparam int LA_W = (IMG * IMG > 1) ? $clog2(IMG * IMG) : 1,
    localparam int OI_W = (OUT * OUT > 1) ? $clog2(OUT * OUT) : 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic             ld_sel,
    input  logic [LA_W-1:0]  ld_addr,
    input  logic [DW-1:0]    ld_data,
    input  logic             start,
    input  logic [4:0]       shift_amt,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [OI_W-1:0]  out_idx
);

    localparam int KK    = KER * KER;
    localparam int NPE   = OUT * OUT;
    localparam int T_C   = KK + 2 * OUT - 2;
    localparam int CNT_W = $clog2(T_C + 1);
    localparam int KI_W  = (KER > 1) ? $clog2(KER) : 1;
    localparam int FA_W  = (KK > 1) ? $clog2(KK) : 1;
    localparam int NTAP  = 2 * OUT - 1;
    localparam int NDL   = (OUT > 1) ? 2 * OUT - 2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_EMIT, S_FIN} state_t;

    // One filter term travelling down the skew line: its (i,j) position and weight.
    typedef struct packed {
        logic            v;
        logic [KI_W-1:0] i;
        logic [KI_W-1:0] j;
        logic [DW-1:0]   w;
    } tok_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [KI_W-1:0]    ti_q, tj_q;
    logic [4:0]         shift_q;
    logic               busy_q, done_q, out_valid_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [OI_W-1:0]    out_idx_q;
    logic [DW-1:0]      img_q [IMG*IMG];
    logic [DW-1:0]      flt_q [KK];
    tok_t               dl_q  [NDL];
    tok_t               tap   [NTAP];
    tok_t               src;
    logic               start_acc;
    logic [ACC_W-1:0]   acc_v [NPE];
    logic [ACC_W-1:0]   acc0_d;

    assign start_acc = (state_q == S_IDLE) && start;

    function automatic logic [OUT_W-1:0] scale_sat(input logic [ACC_W-1:0] acc,
                                                   input logic [4:0]       sh);
        logic [ACC_W-1:0] y;
        y = acc >> sh;
        if ((y >> OUT_W) != '0) return '1;
        return OUT_W'(y);
    endfunction

    always_comb begin
        // NOTE: default every field first so no path leaves src unassigned (no latch).
        src = '0;
        if (state_q == S_COMPUTE && cnt_q < CNT_W'(KK)) begin
            src.v = 1'b1;
            src.i = ti_q;
            src.j = tj_q;
            src.w = flt_q[FA_W'(cnt_q)];
        end
    end

    // Tap d is the source term delayed d cycles; PE(r,c) reads tap r+c.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < NDL; d++) dl_q[d] <= '0;
        end else if (start_acc) begin
            for (int d = 0; d < NDL; d++) dl_q[d] <= '0;
        end else begin
            dl_q[0] <= src;
            for (int d = 1; d < NDL; d++) dl_q[d] <= dl_q[d-1];
        end
    end

    assign tap[0] = src;
    for (genvar d = 1; d < NTAP; d++) begin : g_tap
        assign tap[d] = dl_q[d-1];
    end

    for (genvar r = 0; r < OUT; r++) begin : g_row
        for (genvar c = 0; c < OUT; c++) begin : g_col
            tok_t             tp;
            logic [LA_W-1:0]  pix_addr;
            logic [2*DW-1:0]  prod;
            logic [ACC_W-1:0] acc_q, acc_d;

            assign tp       = tap[r+c];
            assign pix_addr = LA_W'((r + int'(tp.i)) * IMG + c + int'(tp.j));
            assign prod     = (2*DW)'(img_q[pix_addr]) * (2*DW)'(tp.w);

            always_comb begin
                acc_d = acc_q;
                if (start_acc)
                    acc_d = '0;
                else if (tp.v)
                    acc_d = acc_q + ACC_W'(prod);
            end

            always_ff @(posedge clk_in or negedge rst) begin
                if (!rst) acc_q <= '0;
                else      acc_q <= acc_d;
            end

            assign acc_v[r*OUT+c] = acc_q;
            if (r == 0 && c == 0) begin : g_first
                // PE(0,0) may take its last term on the same edge that enters EMIT.
                assign acc0_d = acc_d;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            // NOTE: buffers are flop arrays, so they can be and are cleared by reset like any other state.
            for (int a = 0; a < IMG*IMG; a++) img_q[a] <= '0;
            for (int a = 0; a < KK; a++)      flt_q[a] <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ld_valid) begin
                        if (ld_sel) begin
                            if ({1'b0, ld_addr} < (LA_W+1)'(KK))
                                flt_q[FA_W'(ld_addr)] <= ld_data;
                        end else if ({1'b0, ld_addr} < (LA_W+1)'(IMG*IMG)) begin
                            img_q[ld_addr] <= ld_data;
                        end
                    end
                    if (start) begin
                        state_q <= S_COMPUTE;
                        busy_q  <= 1'b1;
                        shift_q <= shift_amt;
                        cnt_q   <= '0;
                        ti_q    <= '0;
                        tj_q    <= '0;
                    end
                end
                S_COMPUTE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (src.v) begin
                        if (tj_q == KI_W'(KER-1)) begin
                            tj_q <= '0;
                            ti_q <= ti_q + KI_W'(1);
                        end else begin
                            tj_q <= tj_q + KI_W'(1);
                        end
                    end
                    if (cnt_q == CNT_W'(T_C-1)) begin
                        state_q     <= S_EMIT;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= '0;
                        out_data_q  <= scale_sat(acc0_d, shift_q);
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (out_idx_q == OI_W'(NPE-1)) begin
                            state_q     <= S_FIN;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            out_idx_q  <= out_idx_q + OI_W'(1);
                            out_data_q <= scale_sat(acc_v[out_idx_q + OI_W'(1)], shift_q);
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_param_conv_systolic_engine.sv
// Self-checking bench: table of 4x4/3x3 jobs plus hand-written stall, abort and
// 6x6 sequences; results checked through an expected-output queue.
module tb_param_conv_systolic_engine;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] idx;
    } exp_t;

    typedef struct {
        int img_mode;
        int flt_mode;
        int shift;
        bit with_start;
        int want [4];
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel6 = 1'b0;
    logic       ld_valid = 1'b0, ld_sel = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [5:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic [4:0] shift_amt = '0;

    logic       busy4, done4, ov4, busy6, done6, ov6;
    logic [7:0] od4, od6;
    logic [1:0] oi4;
    logic [3:0] oi6;
    logic       o_busy, o_done, o_valid;
    logic [7:0] o_data;
    logic [3:0] o_idx;

    always #5 clk = ~clk;

    param_conv_systolic_engine u_dut4 (
        .clk_in(clk), .rst(rst),
        .ld_valid(ld_valid & ~sel6), .ld_sel(ld_sel), .ld_addr(ld_addr[3:0]), .ld_data(ld_data),
        .start(start & ~sel6), .shift_amt(shift_amt),
        .busy(busy4), .done(done4), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_idx(oi4)
    );

    param_conv_systolic_engine #(.IMG(6), .KER(3)) u_dut6 (
        .clk_in(clk), .rst(rst),
        .ld_valid(ld_valid & sel6), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start & sel6), .shift_amt(shift_amt),
        .busy(busy6), .done(done6), .out_valid(ov6), .out_ready(out_ready),
        .out_data(od6), .out_idx(oi6)
    );

    assign o_busy  = sel6 ? busy6 : busy4;
    assign o_done  = sel6 ? done6 : done4;
    assign o_valid = sel6 ? ov6 : ov4;
    assign o_data  = sel6 ? od6 : od4;
    assign o_idx   = sel6 ? oi6 : {2'b00, oi4};

    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, n_done = 0, n_hs = 0, last_hs_cyc = -10;
    exp_t sb [$];
    exp_t mon_e;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [3:0] prev_idx = '0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pops the expected queue on every handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (o_done) begin
                n_done++;
                check("done_after_last_hs", cyc, last_hs_cyc + 1);
            end
            if (o_valid) begin
                if (prev_stall) begin
                    check("stall_data_held", int'(o_data), int'(prev_data));
                    check("stall_idx_held", int'(o_idx), int'(prev_idx));
                end
                if (out_ready) begin
                    check("output_expected", int'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        check("out_data", int'(o_data), int'(mon_e.data));
                        check("out_idx", int'(o_idx), int'(mon_e.idx));
                    end
                    n_hs++;
                    last_hs_cyc = cyc;
                end
                prev_stall = !out_ready;
                prev_data  = o_data;
                prev_idx   = o_idx;
            end else begin
                prev_stall = 1'b0;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic int img_val(input int mode, input int a);
        return (mode == 0) ? a : 255;
    endfunction

    function automatic int flt_val(input int mode, input int a);
        case (mode)
            0:       return 1;
            1:       return 255;
            2:       return (a == 0) ? 2 : 0;
            3:       return (a == 8) ? 3 : 0;
            default: return a;
        endcase
    endfunction

    task automatic push_exp(input int data, input int idx);
        exp_t e;
        e.data = 8'(data);
        e.idx  = 4'(idx);
        sb.push_back(e);
    endtask

    task automatic ld(input bit sel, input int addr, input int data);
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_addr  = 6'(addr);
        ld_data  = 8'(data);
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    // Loads the 4x4 image and 3x3 filter; the last filter write may carry start.
    task automatic load4(input int im, input int fm, input bit with_start, input int sh);
        for (int a = 0; a < 16; a++) ld(1'b0, a, img_val(im, a));
        ld(1'b1, 12, 99);
        for (int a = 0; a < 8; a++) ld(1'b1, a, flt_val(fm, a));
        ld_valid  = 1'b1;
        ld_sel    = 1'b1;
        ld_addr   = 6'd8;
        ld_data   = 8'(flt_val(fm, 8));
        start     = with_start;
        shift_amt = 5'(sh);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic start_job(input int sh);
        start     = 1'b1;
        shift_amt = 5'(sh);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready 1,0,0,1 pattern; 2: stray start in COMPUTE and load in EMIT.
    task automatic run_job(input int tc, input int mode);
        int n, d0;
        bit fin;
        d0 = n_done;
        check("busy_after_start", int'(o_busy), 1);
        n = 0;
        while (!o_valid && n < 200) begin
            start = (mode == 2 && n == 4);
            if (mode == 2 && n >= 4) shift_amt = 5'd3;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("compute_cycles", n, tc);
        n   = 0;
        fin = 1'b0;
        while (!fin && n < 300) begin
            out_ready = (mode == 1) ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
            if (mode == 2 && n == 2) begin
                ld_valid = 1'b1; ld_sel = 1'b0; ld_addr = 6'd0; ld_data = 8'd200;
            end else begin
                ld_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            fin = (n_done > d0) && (sb.size() == 0);
        end
        ld_valid  = 1'b0;
        out_ready = 1'b1;
        check("job_completed", int'(fin), 1);
        repeat (3) begin @(posedge clk); #1; end
        check("exactly_one_done", n_done - d0, 1);
        check("busy_low_after_done", int'(o_busy), 0);
        sb.delete();
    endtask

    vec_t vecs [7];
    int   t1 [4];

    initial begin
        int n, hs0, d0;
        t1 = '{45, 54, 81, 90};
        vecs[0] = '{img_mode: 0, flt_mode: 0, shift: 0,  with_start: 1'b1, want: '{45, 54, 81, 90}};
        vecs[1] = '{img_mode: 0, flt_mode: 0, shift: 2,  with_start: 1'b0, want: '{11, 13, 20, 22}};
        vecs[2] = '{img_mode: 1, flt_mode: 1, shift: 0,  with_start: 1'b0, want: '{255, 255, 255, 255}};
        vecs[3] = '{img_mode: 1, flt_mode: 1, shift: 12, with_start: 1'b0, want: '{142, 142, 142, 142}};
        vecs[4] = '{img_mode: 0, flt_mode: 2, shift: 0,  with_start: 1'b0, want: '{0, 2, 8, 10}};
        vecs[5] = '{img_mode: 0, flt_mode: 3, shift: 0,  with_start: 1'b0, want: '{30, 33, 42, 45}};
        vecs[6] = '{img_mode: 0, flt_mode: 4, shift: 1,  with_start: 1'b0, want: '{129, 147, 201, 219}};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel6 = s[0];
            #1;
            check("rst_busy", int'(o_busy), 0);
            check("rst_done", int'(o_done), 0);
            check("rst_valid", int'(o_valid), 0);
            check("rst_data", int'(o_data), 0);
            check("rst_idx", int'(o_idx), 0);
        end
        sel6 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Buffers are zero out of reset.
        for (int k = 0; k < 4; k++) push_exp(0, k);
        start_job(0);
        run_job(11, 0);

        // Table-driven jobs; the first one issues start together with its last load.
        foreach (vecs[i]) begin
            for (int k = 0; k < 4; k++) push_exp(vecs[i].want[k], k);
            load4(vecs[i].img_mode, vecs[i].flt_mode, vecs[i].with_start, vecs[i].shift);
            if (!vecs[i].with_start) start_job(vecs[i].shift);
            run_job(11, 0);
        end

        // Back-pressure pattern.
        load4(0, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++) push_exp(t1[k], k);
        start_job(0);
        run_job(11, 1);

        // Stray start and load while busy, then a rerun on retained buffers.
        for (int k = 0; k < 4; k++) push_exp(t1[k], k);
        start_job(0);
        run_job(11, 2);
        for (int k = 0; k < 4; k++) push_exp(t1[k], k);
        start_job(0);
        run_job(11, 0);

        // Abort with reset after idx1 has been accepted.
        for (int k = 0; k < 4; k++) push_exp(t1[k], k);
        start_job(0);
        hs0 = n_hs;
        n   = 0;
        while (n_hs < hs0 + 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reached_idx2", n_hs - hs0, 2);
        rst = 1'b0;
        #1;
        check("abort_valid", int'(o_valid), 0);
        check("abort_data", int'(o_data), 0);
        check("abort_idx", int'(o_idx), 0);
        check("abort_busy", int'(o_busy), 0);
        sb.delete();
        d0 = n_done;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("abort_no_done", n_done - d0, 0);
        for (int k = 0; k < 4; k++) push_exp(0, k);
        start_job(0);
        run_job(11, 0);
        load4(0, 0, 1'b0, 0);
        for (int k = 0; k < 4; k++) push_exp(t1[k], k);
        start_job(0);
        run_job(11, 0);

        // 6x6 image, centre-tap filter: output is the interior 4x4.
        sel6 = 1'b1;
        #1;
        for (int a = 0; a < 36; a++) ld(1'b0, a, (7 * a + 3) % 256);
        for (int a = 0; a < 9; a++) ld(1'b1, a, (a == 4) ? 1 : 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                push_exp((7 * ((r + 1) * 6 + c + 1) + 3) % 256, r * 4 + c);
        start_job(0);
        run_job(15, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
